// File: rtl/cordic_vectoring_engine.sv
// Iterative vectoring-mode CORDIC: (x,y) -> (|v|, atan2(y,x)), one micro-rotation per clock.
// Optional CORDIC_GAIN_COMP_EN adds a GAIN state that scales the magnitude by 1/K.
module cordic_vectoring_engine #(
    parameter int DATA_WIDTH = 18,
    parameter int N_PE       = 15
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic signed [DATA_WIDTH-1:0] in_x,
    input  logic signed [DATA_WIDTH-1:0] in_y,
    input  logic                         i_valid_in,
    output logic                         o_ready_in,
    output logic signed [DATA_WIDTH-1:0] out_magnitude,
    output logic signed [DATA_WIDTH-1:0] out_alpha,
    output logic                         o_valid_out,
    input  logic                         i_ready_out
);

    localparam int XW = DATA_WIDTH + 2;
    localparam int CW = (N_PE > 1) ? $clog2(N_PE) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PREROT = 3'd1;
    localparam logic [2:0] S_ITER   = 3'd2;
    localparam logic [2:0] S_GAIN   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic signed [DATA_WIDTH-1:0] HALF_PI = DATA_WIDTH'(25736);
    localparam logic signed [XW-1:0]         MAG_MAX = XW'((1 << (DATA_WIDTH - 1)) - 1);

    // round(atan(2^-i) * 2^14)
    function automatic int atan_lut(input int i);
        case (i)
            0:       return 12868;
            1:       return 7596;
            2:       return 4014;
            3:       return 2037;
            4:       return 1023;
            5:       return 512;
            6:       return 256;
            7:       return 128;
            8:       return 64;
            9:       return 32;
            10:      return 16;
            11:      return 8;
            12:      return 4;
            13:      return 2;
            14:      return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat_mag(input logic signed [XW-1:0] v);
        if (v[XW-1])
            return '0;
        else if (v > MAG_MAX)
            return MAG_MAX[DATA_WIDTH-1:0];
        else
            return v[DATA_WIDTH-1:0];
    endfunction

    logic [2:0]                   state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         vld_q, vld_d;
    logic signed [DATA_WIDTH-1:0] mag_q, mag_d;
    logic signed [DATA_WIDTH-1:0] alpha_q, alpha_d;
    logic signed [XW-1:0]         x_q, x_d, y_q, y_d;
    logic signed [DATA_WIDTH-1:0] z_q, z_d;
    logic                         zero_q, zero_d;

    logic signed [XW-1:0]         xs, ys;
    logic signed [DATA_WIDTH-1:0] atan_v;

    assign xs     = x_q >>> cnt_q;
    assign ys     = y_q >>> cnt_q;
    assign atan_v = DATA_WIDTH'(atan_lut(int'(cnt_q)));

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [15:0] GAIN_K = 16'sh26de;
    logic signed [XW+13:0] prod;
    assign prod = x_q * GAIN_K;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        mag_d   = mag_q;
        alpha_d = alpha_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        case (state_q)
            // capture the vector; an all-zero input has no defined angle and reports 0
            S_IDLE: begin
                if (i_valid_in) begin
                    x_d     = {{2{in_x[DATA_WIDTH-1]}}, in_x};
                    y_d     = {{2{in_y[DATA_WIDTH-1]}}, in_y};
                    zero_d  = (in_x == '0) && (in_y == '0);
                    state_d = S_PREROT;
                end
            end
            // fold left half-plane into the right half-plane so the iterations converge
            S_PREROT: begin
                if (x_q[XW-1]) begin
                    if (!y_q[XW-1]) begin
                        x_d = y_q;
                        y_d = -x_q;
                        z_d = HALF_PI;
                    end else begin
                        x_d = -y_q;
                        y_d = x_q;
                        z_d = -HALF_PI;
                    end
                end else begin
                    z_d = '0;
                end
                cnt_d   = '0;
                state_d = S_ITER;
            end
            // drive y toward zero, accumulating the rotated angle in z
            S_ITER: begin
                if (y_q[XW-1]) begin
                    x_d = x_q - ys;
                    y_d = y_q + xs;
                    z_d = z_q - atan_v;
                end else begin
                    x_d = x_q + ys;
                    y_d = y_q - xs;
                    z_d = z_q + atan_v;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N_PE - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = S_GAIN;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_GAIN: begin
`ifdef CORDIC_GAIN_COMP_EN
                x_d = prod[XW+13:14];
`endif
                state_d = S_DONE;
            end
            // first cycle registers the result, then hold until downstream takes it
            S_DONE: begin
                if (!vld_q) begin
                    vld_d   = 1'b1;
                    mag_d   = sat_mag(x_q);
                    alpha_d = zero_q ? '0 : z_q;
                end else if (i_ready_out) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            mag_q   <= '0;
            alpha_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            mag_q   <= mag_d;
            alpha_q <= alpha_d;
        end
    end

    always_ff @(posedge i_clk) begin
        x_q    <= x_d;
        y_q    <= y_d;
        z_q    <= z_d;
        zero_q <= zero_d;
    end

    assign o_ready_in    = (state_q == S_IDLE);
    assign o_valid_out   = vld_q;
    assign out_magnitude = mag_q;
    assign out_alpha     = alpha_q;

endmodule

// File: tb/tb_cordic_vectoring_engine.sv
// Directed bench for cordic_vectoring_engine; expectations adapt to CORDIC_GAIN_COMP_EN.
module tb_cordic_vectoring_engine;

    localparam int DW  = 18;
    localparam int NPE = 15;
    localparam int TOL = 4;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT  = NPE + 3;
    localparam bit COMP = 1'b1;
`else
    localparam int LAT  = NPE + 2;
    localparam bit COMP = 1'b0;
`endif

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b0;
    logic signed [DW-1:0] in_x = '0;
    logic signed [DW-1:0] in_y = '0;
    logic                 i_valid_in = 1'b0;
    logic                 o_ready_in;
    logic signed [DW-1:0] out_magnitude;
    logic signed [DW-1:0] out_alpha;
    logic                 o_valid_out;
    logic                 i_ready_out = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    cordic_vectoring_engine #(.DATA_WIDTH(DW), .N_PE(NPE)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .in_x          (in_x),
        .in_y          (in_y),
        .i_valid_in    (i_valid_in),
        .o_ready_in    (o_ready_in),
        .out_magnitude (out_magnitude),
        .out_alpha     (out_alpha),
        .o_valid_out   (o_valid_out),
        .i_ready_out   (i_ready_out)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int    x;
        int    y;
        int    alpha;
        bit    abs_a;
        int    mag;      // -1: magnitude not checked for this vector
        string name;
    } vec_t;

    function automatic vec_t mk(input int x, input int y, input int a, input bit abs_a,
                                input int mag, input string name);
        vec_t v;
        v.x = x; v.y = y; v.alpha = a; v.abs_a = abs_a; v.mag = mag; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input bit ok, input int act, input int exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int exp);
        check(name, (act - exp <= TOL) && (exp - act <= TOL), act, exp);
    endtask

    task automatic send_and_wait(input int x, input int y, output int lat, output bit to);
        @(negedge i_clk);
        check("ready_before_send", o_ready_in == 1'b1, int'(o_ready_in), 1);
        in_x = DW'(x);
        in_y = DW'(y);
        i_valid_in = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid_in = 1'b0;
        lat = 0;
        to  = 1'b0;
        while (!o_valid_out && !to) begin
            @(posedge i_clk);
            #1;
            lat++;
            if (lat > 200) to = 1'b1;
        end
    endtask

    task automatic consume();
        @(negedge i_clk);
        i_ready_out = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready_out = 1'b0;
        check("consumed", !o_valid_out && o_ready_in, int'({o_valid_out, o_ready_in}), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[7];
        int   lat, a, m, a0, m0, bad;
        bit   to;

        tv[0] = mk(16384, 0, 0, 1'b0, COMP ? 16384 : 26981, "x1_y0");
        tv[1] = mk(0, 16384, 25736, 1'b0, COMP ? 16384 : 26981, "x0_ypos");
        tv[2] = mk(0, -16384, -25736, 1'b0, -1, "x0_yneg");
        tv[3] = mk(-16384, 0, 51472, 1'b1, -1, "xneg_y0");
        tv[4] = mk(11585, 11585, 12868, 1'b0, COMP ? 16384 : -1, "diag");
        tv[5] = mk(-131072, -131072, -38604, 1'b0, 131071, "min_min");
        tv[6] = mk(0, 0, 0, 1'b0, 0, "zero");

        // asynchronous reset with no clock edge involved
        #1 i_rst = 1'b1;
        #2;
        check("rst_valid", o_valid_out == 1'b0, int'(o_valid_out), 0);
        check("rst_ready", o_ready_in == 1'b1, int'(o_ready_in), 1);
        check("rst_mag", out_magnitude == '0, int'(out_magnitude), 0);
        check("rst_alpha", out_alpha == '0, int'(out_alpha), 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            send_and_wait(tv[k].x, tv[k].y, lat, to);
            check({tv[k].name, "_latency"}, !to && lat == LAT, lat, LAT);
            a = int'(out_alpha);
            if (tv[k].abs_a && a < 0) a = -a;
            check_tol({tv[k].name, "_alpha"}, a, tv[k].alpha);
            if (tv[k].mag >= 0) begin
                m = int'(out_magnitude);
                check_tol({tv[k].name, "_mag"}, m, tv[k].mag);
            end
            consume();
        end

        // downstream stall: result held, busy input pulses ignored, delivered once
        send_and_wait(16384, 16384, lat, to);
        check("stall_latency", !to && lat == LAT, lat, LAT);
        a0 = int'(out_alpha);
        m0 = int'(out_magnitude);
        check_tol("stall_alpha", a0, 12868);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            i_valid_in = (k % 2 == 0);
            in_x = DW'(-5000 + k);
            in_y = DW'(777);
            @(posedge i_clk);
            #1;
            if (!(o_valid_out && !o_ready_in && int'(out_alpha) == a0 && int'(out_magnitude) == m0))
                bad++;
        end
        i_valid_in = 1'b0;
        check("stall_hold_bad_cycles", bad == 0, bad, 0);
        consume();
        bad = 0;
        for (int k = 0; k < NPE + 6; k++) begin
            @(posedge i_clk);
            #1;
            if (o_valid_out || !o_ready_in) bad++;
        end
        check("no_replay_bad_cycles", bad == 0, bad, 0);

        // reset while iterating (i=5)
        @(negedge i_clk);
        in_x = DW'(16384);
        in_y = DW'(0);
        i_valid_in = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid_in = 1'b0;
        repeat (6) @(posedge i_clk);
        #2;
        check("iter_busy_before_rst", o_ready_in == 1'b0, int'(o_ready_in), 0);
        i_rst = 1'b1;
        #1;
        check("iter_rst_valid", o_valid_out == 1'b0, int'(o_valid_out), 0);
        check("iter_rst_ready", o_ready_in == 1'b1, int'(o_ready_in), 1);
        @(negedge i_clk);
        i_rst = 1'b0;

        send_and_wait(16384, 16384, lat, to);
        check("after_iter_rst_latency", !to && lat == LAT, lat, LAT);
        check_tol("after_iter_rst_alpha", int'(out_alpha), 12868);

        // reset while holding a result
        #2;
        i_rst = 1'b1;
        #1;
        check("done_rst_valid", o_valid_out == 1'b0, int'(o_valid_out), 0);
        check("done_rst_ready", o_ready_in == 1'b1, int'(o_ready_in), 1);
        check("done_rst_alpha", out_alpha == '0, int'(out_alpha), 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        send_and_wait(-16384, 16384, lat, to);
        check("after_done_rst_latency", !to && lat == LAT, lat, LAT);
        check_tol("after_done_rst_alpha", int'(out_alpha), 38604);
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
